// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues instruction-SRAM reads
// and offers {pc, pc_en, ex, ecode, esubcode} to pre-decode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | one dead cycle after reset, no offer; redirects still load pc
// RUN     | normal fetch, one offer per cycle when not redirected/stalled
// HALT    | an ADEF offer was handed over; wait for ex_en or ertn_flush
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter logic [7:0]  ADEF_ECODE = 8'h08
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pD_allowin,
    output logic        FpD_valid,
    output logic [42:0] FpD_BUS,
    input  logic        predict_taken,
    input  logic [31:0] predict_target,
    input  logic        BTB_stall,
    input  logic        predict_error,
    input  logic [31:0] correct_target,
    input  logic        ex_en,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [31:0] pc_f_q, pc_f_d;
    logic [1:0]  state_q, state_d;
    logic        pred_done_q, pred_done_d;

    logic        pred_redirect;
    logic        redirect;
    logic        transfer;
    logic        adef;
    logic [7:0]  ecode;

    // Offer, SRAM strobe and bus fields; a redirect cycle never issues a read
    // so the wrong-path instruction is never fetched.
    always_comb begin
        pred_redirect   = predict_taken & ~pred_done_q;
        redirect        = ex_en | ertn_flush | predict_error | pred_redirect;
        FpD_valid       = rstn & (state_q == ST_RUN) & ~redirect & ~BTB_stall;
        inst_sram_en    = FpD_valid & pD_allowin;
        transfer        = inst_sram_en;
        adef            = (pc_f_q[1:0] != 2'b00);
        ecode           = adef ? ADEF_ECODE : 8'h00;
        FpD_BUS         = {pc_f_q, 1'b1, adef, ecode, 1'b0};
        inst_sram_addr  = pc_f_q;
        inst_sram_we    = 4'b0000;
        inst_sram_wdata = 32'h0000_0000;
    end

    // Next PC by redirect priority; HALT only reacts to ex_en / ertn_flush.
    always_comb begin
        pc_f_d = pc_f_q;
        if (state_q == ST_HALT) begin
            if (ex_en)
                pc_f_d = ex_entry;
            else if (ertn_flush)
                pc_f_d = era;
        end else if (ex_en) begin
            pc_f_d = ex_entry;
        end else if (ertn_flush) begin
            pc_f_d = era;
        end else if (predict_error) begin
            pc_f_d = correct_target;
        end else if (pred_redirect) begin
            pc_f_d = predict_target;
        end else if (transfer) begin
            pc_f_d = pc_f_q + 32'd4;
        end
    end

    // A held predict_taken redirects only once per pre-decode instruction;
    // the flag drops when pre-decode moves on or a stronger redirect lands.
    always_comb begin
        pred_done_d = pred_done_q;
        if (ex_en | ertn_flush | predict_error | pD_allowin)
            pred_done_d = 1'b0;
        else if (pred_redirect)
            pred_done_d = 1'b1;
    end

    // Fetch control state transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  if (transfer && adef) state_d = ST_HALT;
            ST_HALT: if (ex_en || ertn_flush) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_f_q      <= RESET_PC;
            state_q     <= ST_IDLE;
            pred_done_q <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            state_q     <= state_d;
            pred_done_q <= pred_done_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, back-pressure, predicted
// redirect, redirect priority, ADEF/HALT/ertn, BTB stall and mid-run reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pD_allowin;
    logic        FpD_valid;
    logic [42:0] FpD_BUS;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        BTB_stall;
    logic        predict_error;
    logic [31:0] correct_target;
    logic        ex_en;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] era;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rstn           (rstn),
        .pD_allowin     (pD_allowin),
        .FpD_valid      (FpD_valid),
        .FpD_BUS        (FpD_BUS),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .BTB_stall      (BTB_stall),
        .predict_error  (predict_error),
        .correct_target (correct_target),
        .ex_en          (ex_en),
        .ex_entry       (ex_entry),
        .ertn_flush     (ertn_flush),
        .era            (era),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] bus(input logic [31:0] pc, input logic ex, input logic [7:0] ec);
        return {pc, 1'b1, ex, ec, 1'b0};
    endfunction

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer_chk(input string tag, input logic [31:0] pc, input logic en);
        chk({tag, "_valid"}, 64'(FpD_valid), 64'd1);
        chk({tag, "_bus"}, 64'(FpD_BUS), 64'(bus(pc, 1'b0, 8'h00)));
        chk({tag, "_sram_en"}, 64'(inst_sram_en), 64'(en));
        chk({tag, "_addr"}, 64'(inst_sram_addr), 64'(pc));
    endtask

    initial begin
        rstn = 1'b0;
        pD_allowin = 1'b1;
        predict_taken = 1'b0;
        predict_target = 32'h0;
        BTB_stall = 1'b0;
        predict_error = 1'b0;
        correct_target = 32'h0;
        ex_en = 1'b0;
        ex_entry = 32'h0;
        ertn_flush = 1'b0;
        era = 32'h0;

        tick;
        tick;
        #1;
        chk("rst_valid", 64'(FpD_valid), 64'd0);
        chk("rst_sram_en", 64'(inst_sram_en), 64'd0);
        chk("rst_addr", 64'(inst_sram_addr), 64'h1c000000);
        chk("rst_we", 64'(inst_sram_we), 64'd0);
        chk("rst_wdata", 64'(inst_sram_wdata), 64'd0);

        rstn = 1'b1;
        #1;
        chk("idle_valid", 64'(FpD_valid), 64'd0);
        chk("idle_sram_en", 64'(inst_sram_en), 64'd0);
        tick;

        for (int i = 0; i < 4; i++) begin
            #1;
            offer_chk("seq", 32'h1c000000 + 32'(4 * i), 1'b1);
            tick;
        end

        pD_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            offer_chk("bp_hold", 32'h1c000010, 1'b0);
            tick;
        end
        pD_allowin = 1'b1;
        #1;
        offer_chk("bp_release", 32'h1c000010, 1'b1);
        tick;

        predict_taken = 1'b1;
        predict_target = 32'h1c000100;
        pD_allowin = 1'b0;
        #1;
        chk("pt_redir_valid", 64'(FpD_valid), 64'd0);
        chk("pt_redir_sram_en", 64'(inst_sram_en), 64'd0);
        tick;
        for (int i = 0; i < 3; i++) begin
            #1;
            offer_chk("pt_held", 32'h1c000100, 1'b0);
            tick;
        end
        pD_allowin = 1'b1;
        #1;
        offer_chk("pt_transfer", 32'h1c000100, 1'b1);
        tick;
        predict_taken = 1'b0;
        #1;
        offer_chk("pt_next", 32'h1c000104, 1'b1);

        ex_en = 1'b1;
        ex_entry = 32'h1c008000;
        predict_error = 1'b1;
        correct_target = 32'h1c000200;
        predict_taken = 1'b1;
        predict_target = 32'h1c000400;
        #1;
        chk("prio_redir_valid", 64'(FpD_valid), 64'd0);
        chk("prio_redir_sram_en", 64'(inst_sram_en), 64'd0);
        tick;
        ex_en = 1'b0;
        predict_error = 1'b0;
        predict_taken = 1'b0;
        #1;
        offer_chk("prio_target", 32'h1c008000, 1'b1);
        tick;

        predict_taken = 1'b1;
        predict_target = 32'h1c000102;
        #1;
        chk("adef_redir_valid", 64'(FpD_valid), 64'd0);
        tick;
        predict_taken = 1'b0;
        #1;
        chk("adef_valid", 64'(FpD_valid), 64'd1);
        chk("adef_bus", 64'(FpD_BUS), 64'(bus(32'h1c000102, 1'b1, 8'h08)));
        chk("adef_sram_en", 64'(inst_sram_en), 64'd1);
        tick;
        #1;
        chk("halt_valid", 64'(FpD_valid), 64'd0);
        chk("halt_sram_en", 64'(inst_sram_en), 64'd0);
        predict_error = 1'b1;
        correct_target = 32'h1c000600;
        #1;
        chk("halt_perr_valid", 64'(FpD_valid), 64'd0);
        tick;
        predict_error = 1'b0;
        #1;
        chk("halt_stays_valid", 64'(FpD_valid), 64'd0);
        ertn_flush = 1'b1;
        era = 32'h1c000050;
        #1;
        chk("ertn_redir_valid", 64'(FpD_valid), 64'd0);
        tick;
        ertn_flush = 1'b0;
        #1;
        offer_chk("ertn_target", 32'h1c000050, 1'b1);
        tick;

        BTB_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("btb_valid", 64'(FpD_valid), 64'd0);
            chk("btb_sram_en", 64'(inst_sram_en), 64'd0);
            chk("btb_addr", 64'(inst_sram_addr), 64'h1c000054);
            tick;
        end
        BTB_stall = 1'b0;
        predict_error = 1'b1;
        correct_target = 32'h1c000300;
        #1;
        chk("perr_redir_valid", 64'(FpD_valid), 64'd0);
        chk("perr_redir_sram_en", 64'(inst_sram_en), 64'd0);
        tick;
        predict_error = 1'b0;
        #1;
        offer_chk("perr_target", 32'h1c000300, 1'b1);
        tick;

        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(FpD_valid), 64'd0);
        chk("mid_rst_sram_en", 64'(inst_sram_en), 64'd0);
        tick;
        rstn = 1'b1;
        #1;
        chk("mid_idle_valid", 64'(FpD_valid), 64'd0);
        chk("mid_idle_addr", 64'(inst_sram_addr), 64'h1c000000);
        tick;
        #1;
        offer_chk("mid_first", 32'h1c000000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
